// File: rtl/multihot_index_encoder_pkg.sv
// Shared types and sizing helpers for the multi-hot to index serialiser.
package multihot_index_encoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        ERR  = 2'd2
    } state_e;

    localparam int DEF_N = 4;

    // Index width for an N-wide vector; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multihot_index_encoder_lsb_priority_encoder.sv
// Combinational lowest-set-bit finder: binary index, one-hot mask, any-set flag.
module lsb_priority_encoder
    import multihot_index_encoder_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic [N-1:0] mask_o,
    output logic         any_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o  = '0;
        mask_o = '0;
        any_o  = |vec_i;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o     = W'(i);
                mask_o    = '0;
                mask_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multihot_index_encoder.sv
// Serialises a multi-hot request vector into one binary index per beat, lowest first.
module multihot_index_encoder
    import multihot_index_encoder_pkg::*;
#(
    parameter  int N = DEF_N,
    localparam int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_err
);

    state_e       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;

    logic [W-1:0] low_idx;
    logic [N-1:0] low_mask;
    logic         pend_any;
    logic [N-1:0] pend_rest;

    lsb_priority_encoder #(.N(N), .W(W)) u_lsb (
        .vec_i  (pend_q),
        .idx_o  (low_idx),
        .mask_o (low_mask),
        .any_o  (pend_any)
    );

    assign pend_rest = pend_q & ~low_mask;

    // Outputs come only from registered state and pend, never from in_* or out_ready.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q != IDLE);
        out_err   = (state_q == ERR);
        out_idx   = '0;
        out_last  = 1'b0;
        case (state_q)
            EMIT: begin
                out_idx  = low_idx;
                out_last = pend_any && (pend_rest == '0);
            end
            ERR:     out_last = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pend_d  = in_vec;
                    state_d = (in_vec == '0) ? ERR : EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pend_d = pend_rest;
                    if (pend_rest == '0) state_d = IDLE;
                end
            end
            ERR: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_multihot_index_encoder.sv
// Scoreboard bench: expected beats are queued when a vector is accepted and checked as the sink takes them.
module tb_multihot_index_encoder;

    localparam int N = 4;
    localparam int W = 2;

    typedef struct packed {
        logic [W-1:0] idx;
        logic         last;
        logic         err;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         out_err;

    beat_t exp_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    always #5 clk = ~clk;

    multihot_index_encoder #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_err   (out_err)
    );

    // Every output handshake pops one expected beat.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_beat: got idx=%0d last=%0d err=%0d, expected no beat",
                         out_idx, out_last, out_err);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if ({out_idx, out_last, out_err} !== {e.idx, e.last, e.err})
                    $display("FAIL beat: got idx=%0d last=%0d err=%0d, expected idx=%0d last=%0d err=%0d",
                             out_idx, out_last, out_err, e.idx, e.last, e.err);
                else n_pass++;
            end
        end
    end

    // Reference model: expected beats for one accepted vector.
    task automatic push_expected(input logic [N-1:0] v);
        beat_t b;
        int    cnt;
        int    seen;
        cnt = 0;
        for (int i = 0; i < N; i++) if (v[i]) cnt++;
        if (cnt == 0) begin
            b.idx = '0; b.last = 1'b1; b.err = 1'b1;
            exp_q.push_back(b);
        end else begin
            seen = 0;
            for (int i = 0; i < N; i++) begin
                if (v[i]) begin
                    seen++;
                    b.idx  = W'(i);
                    b.last = (seen == cnt);
                    b.err  = 1'b0;
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    // Present a vector and hold it until accepted (bounded); returns just after the accepting edge.
    task automatic send(input logic [N-1:0] v, output bit ok);
        bit hs;
        ok = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_vec   = v;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk); #1;
            if (hs) begin ok = 1; break; end
        end
        in_valid = 1'b0;
        if (ok) push_expected(v);
    endtask

    task automatic run_drain(input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({in_ready, out_valid, out_idx, out_last, out_err} !== {1'b1, 1'b0, 2'd0, 1'b0, 1'b0})
            $display("FAIL reset: got rdy=%0b vld=%0b idx=%0d last=%0b err=%0b, expected rdy=1 vld=0 idx=0 last=0 err=0",
                     in_ready, out_valid, out_idx, out_last, out_err);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_vector(input string name, input logic [N-1:0] v);
        bit ok;
        out_ready = 1'b1;
        send(v, ok);
        n_chk++;
        if (!ok) $display("FAIL %s_accept: got no input handshake, expected one", name);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b1) $display("FAIL %s_latency: got out_valid=%0b, expected 1", name, out_valid);
        else n_pass++;
        #1;
        run_drain(20);
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL %s_drain: got %0d beats left, expected 0", name, exp_q.size());
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL %s_idle: got rdy=%0b vld=%0b, expected rdy=1 vld=0", name, in_ready, out_valid);
        else n_pass++;
        #1;
    endtask

    task automatic test_backpressure();
        bit ok;
        out_ready = 1'b0;
        send(4'b1111, ok);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++;
            if ({out_valid, out_idx, out_last, out_err} !== {1'b1, 2'd0, 1'b0, 1'b0})
                $display("FAIL bp_hold: got vld=%0b idx=%0d last=%0b err=%0b, expected vld=1 idx=0 last=0 err=0",
                         out_valid, out_idx, out_last, out_err);
            else n_pass++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        run_drain(20);
        n_chk++;
        if (!ok || exp_q.size() != 0) $display("FAIL bp_drain: got ok=%0b left=%0d, expected ok=1 left=0", ok, exp_q.size());
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        out_ready = 1'b1;
        send(4'b1011, ok);
        @(posedge clk); #1;                 // beat idx=0 taken at this edge
        rst = 1'b1;
        n_chk++;
        if (exp_q.size() != 2) $display("FAIL rstmid_pending: got %0d queued, expected 2", exp_q.size());
        else n_pass++;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL rstmid_idle: got rdy=%0b vld=%0b, expected rdy=1 vld=0", in_ready, out_valid);
        else n_pass++;
        #1;
        test_vector("after_rst", 4'b0010);
    endtask

    task automatic test_hold_during_emit();
        bit hs;
        bit done;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_vec   = 4'b0011;
        @(posedge clk); #1;                 // 0011 accepted (block idle)
        push_expected(4'b0011);
        push_expected(4'b1000);
        in_vec = 4'b1000;
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b0) $display("FAIL hold_blocked: got in_ready=%0b, expected 0", in_ready);
        else n_pass++;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            hs = in_ready;
            @(posedge clk); #1;
            if (hs) done = 1;
            else @(negedge clk);
        end
        in_valid = 1'b0;
        run_drain(20);
        n_chk++;
        if (!done || exp_q.size() != 0) $display("FAIL hold_drain: got accepted=%0b left=%0d, expected accepted=1 left=0", done, exp_q.size());
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_random_backpressure();
        bit ok;
        for (int t = 0; t < 8; t++) begin
            out_ready = 1'b1;
            send(N'($urandom_range(0, 15)), ok);
            for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
            end
            n_chk++;
            if (!ok || exp_q.size() != 0) $display("FAIL rand_drain%0d: got ok=%0b left=%0d, expected ok=1 left=0", t, ok, exp_q.size());
            else n_pass++;
            out_ready = 1'b1;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_vector("single", 4'b0100);
        test_vector("multi", 4'b1011);
        test_vector("zero", 4'b0000);
        test_vector("msb", 4'b1000);
        test_backpressure();
        test_reset_mid();
        test_hold_during_emit();
        test_random_backpressure();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
